// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: state encoding,
// legal byte-enable patterns and the access legality check.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int BURST_W = 4;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  // Words need 4-byte alignment, halves 2-byte; any other be pattern is illegal.
  function automatic logic is_illegal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (be)
      BE_WORD:                              r = (addr_lo != 2'b00);
      BE_HALF_LO, BE_HALF_HI:               r = addr_lo[0];
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: r = 1'b0;
      default:                              r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Grant selection: port 1 wins a contested slot unless it has already taken
// MAX_BURST consecutive slots while port 0 was waiting.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic [BURST_W-1:0] i_burst_cnt,
  output logic               o_grant_any,
  output logic               o_grant_sel
);

  logic w_limit;

  assign w_limit     = (i_burst_cnt == BURST_W'(MAX_BURST));
  assign o_grant_any = i_req0 | i_req1;
  assign o_grant_sel = i_req1 & ~(i_req0 & w_limit);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port sequencer in front of the single-port data memory: CPU on port 0,
// DMA/bridge on port 1, one access per three cycles with a registered response.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | selected port drives the memory bus for one cycle
// RESP  | ack/err pulse to the selected port; requests are not arbitrated
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        stall0,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  state_t             r_state;
  logic               r_sel;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [31:0]        r_rdata0;
  logic [31:0]        r_rdata1;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_err0;
  logic               r_err1;

  logic               w_grant_any;
  logic               w_grant_sel;
  logic               w_we_sel;
  logic [31:0]        w_addr_sel;
  logic [31:0]        w_wdata_sel;
  logic [3:0]         w_be_sel;
  logic               w_illegal;
  logic               w_issue;

  dm_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .i_req0      (req0),
    .i_req1      (req1),
    .i_burst_cnt (r_burst_cnt),
    .o_grant_any (w_grant_any),
    .o_grant_sel (w_grant_sel)
  );

  always_comb begin
    w_we_sel    = we0;
    w_addr_sel  = addr0;
    w_wdata_sel = wdata0;
    w_be_sel    = be0;
    if (r_sel) begin
      w_we_sel    = we1;
      w_addr_sel  = addr1;
      w_wdata_sel = wdata1;
      w_be_sel    = be1;
    end
  end

  assign w_illegal = is_illegal(w_be_sel, w_addr_sel[1:0]);
  assign w_issue   = (r_state == ISSUE);

  // Gating with reset keeps a store from landing on the edge that aborts it.
  assign mem_we    = w_issue & w_we_sel & ~w_illegal & reset;
  assign mem_addr  = w_issue ? w_addr_sel  : 32'd0;
  assign mem_wdata = w_issue ? w_wdata_sel : 32'd0;
  assign mem_be    = w_issue ? w_be_sel    : 4'd0;

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign err0   = r_err0;
  assign err1   = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign stall0 = req0 & ~r_ack0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_burst_cnt <= '0;
      r_rdata0    <= 32'd0;
      r_rdata1    <= 32'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!req0) r_burst_cnt <= '0;
          if (w_grant_any) begin
            r_sel   <= w_grant_sel;
            r_state <= ISSUE;
            if (!w_grant_sel) begin
              r_burst_cnt <= '0;
            end else if (req0 && (r_burst_cnt != BURST_W'(MAX_BURST))) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          r_state <= RESP;
          if (r_sel) begin
            r_rdata1 <= mem_rdata;
            r_ack1   <= 1'b1;
            r_err1   <= w_illegal;
          end else begin
            r_rdata0 <= mem_rdata;
            r_ack0   <= 1'b1;
            r_err0   <= w_illegal;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: drivers push expected responses, a monitor
// pops them on every ack; a small byte-lane memory sits behind the arbiter.
module tb_dm_arbiter;

  localparam int MAXB = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [3:0]  be[2];

  logic        ack0, ack1, err0, err1, stall0, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] tb_mem  [64];
  logic [31:0] init_mem[64];
  logic [31:0] ref_mem [64];
  logic        mem_load;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          we_cnt  = 0;
  int          ack1_cnt = 0;
  logic [31:0] last_we_addr;
  logic [3:0]  last_we_be;
  bit          grant_chk = 0;
  int          exp_grant_q[$];
  int          ack0_cyc_q[$];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req[0]),
    .req1      (req[1]),
    .we0       (we[0]),
    .we1       (we[1]),
    .addr0     (addr[0]),
    .addr1     (addr[1]),
    .wdata0    (wdata[0]),
    .wdata1    (wdata[1]),
    .be0       (be[0]),
    .be1       (be[1]),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .stall0    (stall0),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_mem[i];
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) tb_mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_illegal(input logic [3:0] b, input logic [31:0] a);
    if (b == 4'hF) return a[1:0] != 2'b00;
    if (b == 4'h3 || b == 4'hC) return a[0];
    if ($countones(b) == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: sample one time unit after each active edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("stall0", 32'(stall0), 32'(req[0] & ~ack0));
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_be   = mem_be;
    end
    if (ack0) begin
      ack0_cyc_q.push_back(cyc);
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ack0_unexpected: got ack0=1, expected no ack (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check("rdata0", rdata0, e.rdata);
        check("err0", 32'(err0), 32'(e.err));
      end
    end
    if (ack1) begin
      ack1_cnt++;
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ack1_unexpected: got ack1=1, expected no ack (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        check("rdata1", rdata1, e.rdata);
        check("err1", 32'(err1), 32'(e.err));
      end
    end
    if (grant_chk && (ack0 || ack1)) begin
      if (exp_grant_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL grant_extra: got grant to port %0d, expected none", ack1 ? 1 : 0);
      end else begin
        check("grant_order", ack1 ? 32'd1 : 32'd0, 32'(exp_grant_q.pop_front()));
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input bit keep);
    exp_t e;
    int   n;
    logic got;
    e.err   = ref_illegal(b, a);
    e.rdata = ref_mem[a[7:2]];
    if (w && !e.err)
      for (int i = 0; i < 4; i++)
        if (b[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b; req[p] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack, expected ack within 40 cycles", p);
      if (p == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
    if (!keep) req[p] = 1'b0;
  endtask

  function automatic logic [3:0] rand_be();
    logic [3:0] legal[7];
    legal = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return legal[$urandom_range(0, 6)];
  endfunction

  task automatic rand_port(input int p, input int count);
    logic [31:0] a;
    bit          keep;
    for (int k = 0; k < count; k++) begin
      a    = 32'(p * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      keep = (k != count - 1) && ($urandom_range(0, 1) == 1);
      issue(p, 1'($urandom_range(0, 1)), a, $urandom, rand_be(), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, n0, a1, cnt;
    logic [31:0] word8;
    reset = 1'b0;
    mem_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; be[i] = 4'd0;
    end
    for (int i = 0; i < 64; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[4] = 32'hDEADBEEF;
    ref_mem[4]  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_err0", 32'(err0), 0);
    check("rst_err1", 32'(err1), 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    mem_load = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // single CPU load
    c0 = cyc; w0 = we_cnt;
    issue(0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
    check("load_latency", 32'(ack0_cyc_q[ack0_cyc_q.size()-1] - c0), 32'd2);
    check("load_no_write", 32'(we_cnt - w0), 32'd0);
    @(negedge clk);

    // store byte from port 1
    w0 = we_cnt;
    issue(1, 1'b1, 32'h22, 32'h00AB0000, 4'b0100, 1'b0);
    check("store_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("store_addr", last_we_addr, 32'h22);
    check("store_be", 32'(last_we_be), 32'b0100);
    check("store_lane", 32'(tb_mem[8][23:16]), 32'hAB);
    issue(1, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0);
    @(negedge clk);

    // misaligned word store
    w0 = we_cnt;
    issue(0, 1'b1, 32'h13, 32'h12345678, 4'hF, 1'b0);
    check("misaligned_no_write", 32'(we_cnt - w0), 32'd0);
    @(negedge clk);

    // reset asserted while a store is in ISSUE
    word8 = ref_mem[8];
    we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF; req[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_issue_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    reset = 1'b0; req[0] = 1'b0;
    #1;
    check("abort_we_gated", 32'(mem_we), 32'd0);
    @(posedge clk); #2;
    check("abort_ack0", 32'(ack0), 0);
    check("abort_err0", 32'(err0), 0);
    check("abort_rdata0", rdata0, 0);
    check("abort_rdata1", rdata1, 0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_be", 32'(mem_be), 0);
    check("abort_no_write", tb_mem[8], word8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // port 0 back-to-back
    n0 = ack0_cyc_q.size(); a1 = ack1_cnt;
    for (int k = 0; k < 6; k++) issue(0, 1'b0, 32'(k * 4), 32'd0, 4'hF, k != 5);
    for (int k = n0 + 1; k < n0 + 6; k++)
      check("b2b_spacing", 32'(ack0_cyc_q[k] - ack0_cyc_q[k-1]), 32'd3);
    check("b2b_no_port1", 32'(ack1_cnt - a1), 32'd0);
    @(negedge clk);

    // both ports continuously requesting
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == MAXB) begin exp_grant_q.push_back(0); cnt = 0; end
      else begin exp_grant_q.push_back(1); cnt++; end
    end
    grant_chk = 1;
    fork
      for (int k = 0; k < 8; k++)
        issue(1, 1'(k % 2), 32'(64 + k * 4), $urandom, 4'hF, k != 7);
      for (int k = 0; k < 2; k++)
        issue(0, 1'b0, 32'(k * 4 + 8), 32'd0, 4'hF, k != 1);
    join
    grant_chk = 0;
    check("grant_q_drained", 32'(exp_grant_q.size()), 32'd0);
    @(negedge clk);

    // randomized traffic, each port in its own address region
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
